qr_sample: RTL and testbench

Module-grid sampler directly downstream of the QR locator. It takes the locator's bounding box (x0, y0, x1, y1) and module pitch, derives the grid dimension N, and reads the centre pixel of every module from the binary image BRAM. It emits the N×N module bits row-major through a simple write port into the bit-matrix buffer consumed by the decoder. It uses the same level-held enable / sticky end handshake as the locator.

---
 rtl/qr_pkg.sv | 28 ++
 rtl/qr_div_step.sv | 41 ++++
 rtl/qr_sample.sv | 205 ++++++++++++++++++++
 tb/tb_qr_sample.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared definitions for the QR pipeline: sampler state encoding, grid
// limits and the widths shared with the locator and the decoder.
package qr_pkg;

  // Smallest grid the decoder accepts (version 1 symbol).
  localparam int GRID_MIN       = 21;
  // Default largest grid accepted by the sampler.
  localparam int GRID_MAX_DEF   = 21;
  // Module pitch / image address width shared with the locator.
  localparam int MODW_WIDTH     = 16;
  // Bit-matrix address width shared with the decoder.
  localparam int BIT_AW_DEF     = 9;
  // Width of the derived grid dimension.
  localparam int GRID_NW        = 6;
  // Default image BRAM read latency.
  localparam int READ_DELAY_DEF = 5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_CHK  = 3'd2,
    S_ADDR = 3'd3,
    S_WAIT = 3'd4,
    S_WR   = 3'd5,
    S_DONE = 3'd6
  } smp_state_t;

endpackage

// File: rtl/qr_div_step.sv
// Repeated-subtraction divider: one subtraction per cycle after start.
// The quotient saturates at LIMIT so an oversized (or wrapped) dividend
// cannot stall the caller; any quotient at LIMIT is rejected upstream.
module qr_div_step #(
  parameter int DW    = 32,
  parameter int VW    = 16,
  parameter int QW    = 6,
  parameter int LIMIT = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [QW-1:0] quotient,
  output logic          done
);

  logic [DW-1:0] rem_q;
  logic [QW-1:0] quo_q;
  logic          done_d;

  assign done_d   = (rem_q < DW'(divisor)) || (quo_q == QW'(LIMIT));
  assign done     = done_d;
  assign quotient = quo_q;

  // Load on start, otherwise subtract once per cycle until finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
    end else if (start) begin
      rem_q <= dividend;
      quo_q <= '0;
    end else if (!done_d) begin
      rem_q <= rem_q - DW'(divisor);
      quo_q <= quo_q + QW'(1);
    end
  end

endmodule

// File: rtl/qr_sample.sv
// Module-grid sampler: derives N from the locator box and module pitch,
// then reads the centre pixel of each module and writes the N*N bits
// row-major into the bit-matrix buffer.
//
// Handshake: smp_en is a level request held high by the caller until it
// sees smp_end; smp_end (with smp_err) stays high until smp_en falls.
// Dropping smp_en mid-run aborts to IDLE on the next cycle with no
// further writes. At least one low cycle separates two runs.
module qr_sample
  import qr_pkg::*;
#(
  parameter int ADDR_WIDTH_2 = MODW_WIDTH,
  parameter int READ_DELAY   = READ_DELAY_DEF,
  parameter int GRID_MAX     = GRID_MAX_DEF,
  parameter int BIT_AW       = BIT_AW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    smp_en,
  output logic                    smp_end,
  output logic                    smp_err,
  input  logic [31:0]             width,
  input  logic [31:0]             x0,
  input  logic [31:0]             y0,
  input  logic [31:0]             x1,
  input  logic [31:0]             y1,
  input  logic [ADDR_WIDTH_2-1:0] mod_w,
  output logic [ADDR_WIDTH_2-1:0] addra,
  input  logic                    douta,
  output logic [GRID_NW-1:0]      grid_n,
  output logic                    bit_we,
  output logic [BIT_AW-1:0]       bit_addr,
  output logic                    bit_data,
  output smp_state_t              dbg_state
);

  localparam int AW  = ADDR_WIDTH_2;
  localparam int WCW = $clog2(READ_DELAY + 1);

  smp_state_t          state_q;
  logic                smp_end_q, smp_err_q;
  logic [GRID_NW-1:0]  grid_n_q;
  logic [AW-1:0]       addra_q;
  logic                bit_we_q, bit_data_q;
  logic [BIT_AW-1:0]   bit_addr_q, idx_q;
  logic [31:0]         x0_q, y0_q, width_q;
  logic [AW-1:0]       mod_w_q;
  logic                divz_q, spanz_q;
  logic [AW-1:0]       row_step_q, row_addr_q, col_addr_q;
  logic [GRID_NW-1:0]  r_q, c_q;
  logic [WCW-1:0]      wait_q;

  logic [31:0]         span_x_d, span_y_d;
  logic [AW-1:0]       half_d, base_d, row_step_d;
  logic                div_start_d, chk_err_d, last_col_d, last_row_d;
  logic [GRID_NW-1:0]  nx, ny;
  logic                dx_done, dy_done;

  // Spans are exclusive-box widths; a wrapped x0/y0 of all-ones works out.
  assign span_x_d    = x1 - x0 - 32'd1;
  assign span_y_d    = y1 - y0 - 32'd1;
  assign div_start_d = (state_q == S_IDLE) && smp_en;

  // Module centre offset from the box edge, then the first-module address.
  assign half_d     = {1'b0, mod_w_q[AW-1:1]};
  assign base_d     = AW'((y0_q + 32'd1 + 32'(half_d)) * width_q
                          + x0_q + 32'd1 + 32'(half_d));
  assign row_step_d = AW'(width_q * 32'(mod_w_q));

  assign chk_err_d  = divz_q || spanz_q || (nx != ny)
                      || (nx > GRID_NW'(GRID_MAX)) || (nx < GRID_NW'(GRID_MIN));
  assign last_col_d = (c_q == grid_n_q - GRID_NW'(1));
  assign last_row_d = (r_q == grid_n_q - GRID_NW'(1));

  qr_div_step #(
    .DW(32), .VW(AW), .QW(GRID_NW), .LIMIT(GRID_MAX + 1)
  ) u_div_x (
    .clk(clk), .rst_n(rst_n), .start(div_start_d),
    .dividend(span_x_d), .divisor(mod_w_q),
    .quotient(nx), .done(dx_done)
  );

  qr_div_step #(
    .DW(32), .VW(AW), .QW(GRID_NW), .LIMIT(GRID_MAX + 1)
  ) u_div_y (
    .clk(clk), .rst_n(rst_n), .start(div_start_d),
    .dividend(span_y_d), .divisor(mod_w_q),
    .quotient(ny), .done(dy_done)
  );

  // Sampler FSM with its counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      smp_end_q  <= 1'b0;
      smp_err_q  <= 1'b0;
      grid_n_q   <= '0;
      addra_q    <= '0;
      bit_we_q   <= 1'b0;
      bit_addr_q <= '0;
      bit_data_q <= 1'b0;
      idx_q      <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      width_q    <= '0;
      mod_w_q    <= '0;
      divz_q     <= 1'b0;
      spanz_q    <= 1'b0;
      row_step_q <= '0;
      row_addr_q <= '0;
      col_addr_q <= '0;
      r_q        <= '0;
      c_q        <= '0;
      wait_q     <= '0;
    end else begin
      bit_we_q <= 1'b0;
      if ((state_q != S_IDLE) && (state_q != S_DONE) && !smp_en) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (smp_en) begin
              x0_q      <= x0;
              y0_q      <= y0;
              width_q   <= width;
              mod_w_q   <= mod_w;
              divz_q    <= (mod_w == '0);
              spanz_q   <= (span_x_d == 32'd0);
              grid_n_q  <= '0;
              smp_err_q <= 1'b0;
              // A zero pitch cannot be divided; go straight to rejection.
              state_q   <= (mod_w == '0) ? S_CHK : S_DIV;
            end
          end
          S_DIV: begin
            if (dx_done && dy_done) state_q <= S_CHK;
          end
          S_CHK: begin
            if (chk_err_d) begin
              smp_err_q <= 1'b1;
              smp_end_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              grid_n_q   <= nx;
              row_step_q <= row_step_d;
              row_addr_q <= base_d;
              col_addr_q <= base_d;
              r_q        <= '0;
              c_q        <= '0;
              idx_q      <= '0;
              state_q    <= S_ADDR;
            end
          end
          S_ADDR: begin
            addra_q <= col_addr_q;
            wait_q  <= '0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_q == WCW'(READ_DELAY - 1)) state_q <= S_WR;
            else wait_q <= wait_q + WCW'(1);
          end
          S_WR: begin
            bit_we_q   <= 1'b1;
            bit_addr_q <= idx_q;
            bit_data_q <= douta;
            idx_q      <= idx_q + BIT_AW'(1);
            if (!last_col_d) begin
              c_q        <= c_q + GRID_NW'(1);
              col_addr_q <= col_addr_q + mod_w_q;
              state_q    <= S_ADDR;
            end else if (!last_row_d) begin
              r_q        <= r_q + GRID_NW'(1);
              c_q        <= '0;
              row_addr_q <= row_addr_q + row_step_q;
              col_addr_q <= row_addr_q + row_step_q;
              state_q    <= S_ADDR;
            end else begin
              smp_end_q <= 1'b1;
              state_q   <= S_DONE;
            end
          end
          S_DONE: begin
            if (!smp_en) begin
              smp_end_q <= 1'b0;
              smp_err_q <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign smp_end   = smp_end_q;
  assign smp_err   = smp_err_q;
  assign grid_n    = grid_n_q;
  assign addra     = addra_q;
  assign bit_we    = bit_we_q;
  assign bit_addr  = bit_addr_q;
  assign bit_data  = bit_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_qr_sample.sv
// Directed bench for qr_sample: nominal and wrapped-origin grids against a
// checkerboard image, the geometry rejection paths, write spacing, abort
// and asynchronous reset mid-run.
module tb_qr_sample;
  import qr_pkg::*;

  localparam int AW   = 16;
  localparam int BAW  = 9;
  localparam int RD   = 5;
  localparam int EW   = AW + BAW + 1;
  localparam int NMOD = 21 * 21;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               smp_en = 1'b0;
  logic               smp_end, smp_err;
  logic [31:0]        width, x0, y0, x1, y1;
  logic [AW-1:0]      mod_w;
  logic [AW-1:0]      addra;
  logic               douta;
  logic [GRID_NW-1:0] grid_n;
  logic               bit_we;
  logic [BAW-1:0]     bit_addr;
  logic               bit_data;
  smp_state_t         dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int run_wr = 0;
  int first_we_cyc = 0;
  int last_we_cyc = 0;
  int cur_width = 100;
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] pipe [RD];

  qr_sample #(
    .ADDR_WIDTH_2(AW), .READ_DELAY(RD), .GRID_MAX(21), .BIT_AW(BAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .smp_en(smp_en), .smp_end(smp_end),
    .smp_err(smp_err), .width(width), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .mod_w(mod_w), .addra(addra), .douta(douta), .grid_n(grid_n),
    .bit_we(bit_we), .bit_addr(bit_addr), .bit_data(bit_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  // ---------------- image BRAM model ----------------
  // Checkerboard of 4x4-pixel squares; an address is valid READ_DELAY edges later.
  function automatic logic img(input logic [AW-1:0] a);
    int x, y;
    x = int'(a) % cur_width;
    y = int'(a) / cur_width;
    return 1'(((x >> 2) ^ (y >> 2)) & 1);
  endfunction

  always @(posedge clk) begin
    pipe[0] <= addra;
    for (int k = 1; k < RD; k++) pipe[k] <= pipe[k-1];
  end
  assign douta = img(pipe[RD-1]);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every write is matched against the expected queue.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && bit_we) begin
      if (run_wr > 0) check("we_gap", 32'(cyc - last_we_cyc), 32'(RD + 2));
      else first_we_cyc = cyc;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(bit_we), 0);
      end else begin
        e = exp_q.pop_front();
        check("addra", 32'(addra), 32'(e[EW-1:BAW+1]));
        check("bit_addr", 32'(bit_addr), 32'(e[BAW:1]));
        check("bit_data", 32'(bit_data), 32'(e[0]));
      end
      run_wr++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_geom(input int w, input logic [31:0] ax0, input logic [31:0] ay0,
                          input logic [31:0] ax1, input logic [31:0] ay1, input int m);
    width = 32'(w); x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
    mod_w = AW'(m); cur_width = w;
  endtask

  task automatic load_exp(input int base, input int wdt, input int m);
    logic [AW-1:0]  a;
    logic [BAW-1:0] idx;
    exp_q.delete();
    for (int r = 0; r < 21; r++) begin
      for (int c = 0; c < 21; c++) begin
        a   = AW'(base + r * wdt * m + c * m);
        idx = BAW'(r * 21 + c);
        exp_q.push_back({a, idx, img(a)});
      end
    end
  endtask

  task automatic start_run(output int t0);
    run_wr = 0;
    @(negedge clk);
    smp_en = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_end(output int t_end);
    bit seen;
    seen = 1'b0;
    t_end = 0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (smp_end) begin seen = 1'b1; t_end = cyc; end
    end
    if (!seen) check("end_timeout", 32'(smp_end), 1);
  endtask

  task automatic run_ok(input int base, input int wdt, input int m);
    int t0, t_end;
    load_exp(base, wdt, m);
    start_run(t0);
    wait_end(t_end);
    @(negedge clk);
    check("smp_err", 32'(smp_err), 0);
    check("grid_n", 32'(grid_n), 21);
    check("wr_count", 32'(run_wr), NMOD);
    check("first_we_lat", 32'(first_we_cyc - t0), 31);
    check("end_lat", 32'(t_end - t0), 31 + (NMOD - 1) * (RD + 2));
    check("q_left", 32'(exp_q.size()), 0);
    smp_en = 1'b0;
    @(negedge clk);
    check("end_clear", 32'(smp_end), 0);
    exp_q.delete();
  endtask

  task automatic run_err(input int lat);
    int t0, t_end;
    exp_q.delete();
    start_run(t0);
    wait_end(t_end);
    @(negedge clk);
    check("err_flag", 32'(smp_err), 1);
    check("err_wr_count", 32'(run_wr), 0);
    if (lat > 0) check("err_lat", 32'(t_end - t0), 32'(lat));
    smp_en = 1'b0;
    @(negedge clk);
    check("err_end_clear", 32'(smp_end), 0);
    check("err_flag_clear", 32'(smp_err), 0);
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 2000 && run_wr < n; i++) @(negedge clk);
    if (run_wr < n) check("wait_writes", 32'(run_wr), 32'(n));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_addra"}, 32'(addra), 0);
    check({pfx, "_smp_end"}, 32'(smp_end), 0);
    check({pfx, "_smp_err"}, 32'(smp_err), 0);
    check({pfx, "_grid_n"}, 32'(grid_n), 0);
    check({pfx, "_bit_we"}, 32'(bit_we), 0);
    check({pfx, "_bit_addr"}, 32'(bit_addr), 0);
    check({pfx, "_bit_data"}, 32'(bit_data), 0);
    check({pfx, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    set_geom(100, 32'd9, 32'd4, 32'd94, 32'd89, 4);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal 21x21, first module centre at (12,7) -> 712.
    run_ok(712, 100, 4);

    // Wrapped origin: centre of first module at (2,2) -> 170.
    set_geom(84, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd84, 32'd84, 4);
    run_ok(170, 84, 4);

    // Zero pitch: IDLE -> CHK -> DONE.
    set_geom(100, 32'd9, 32'd4, 32'd94, 32'd89, 0);
    run_err(2);

    // Non-square: x span 84 (21), y span 89 (22).
    set_geom(100, 32'd9, 32'd4, 32'd94, 32'd94, 4);
    run_err(0);

    // 25x25 grid exceeds GRID_MAX.
    set_geom(100, 32'd9, 32'd4, 32'd110, 32'd105, 4);
    run_err(0);

    // Abort after the 10th write.
    set_geom(100, 32'd9, 32'd4, 32'd94, 32'd89, 4);
    load_exp(712, 100, 4);
    start_run(t0);
    wait_writes(10);
    smp_en = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(dbg_state), 32'(S_IDLE));
    exp_q.delete();
    repeat (20) @(negedge clk);
    check("abort_wr", 32'(run_wr), 10);
    check("abort_end", 32'(smp_end), 0);

    // Restart after abort runs cleanly from bit_addr 0.
    run_ok(712, 100, 4);

    // Asynchronous reset in the middle of a WAIT.
    load_exp(712, 100, 4);
    start_run(t0);
    wait_writes(3);
    for (int i = 0; i < 20 && dbg_state != S_WAIT; i++) @(negedge clk);
    check("pre_reset_state", 32'(dbg_state), 32'(S_WAIT));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    smp_en = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run after reset.
    run_ok(712, 100, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
